// File: rtl/swan256_engine_arbiter_pkg.sv
// Shared state encoding, default block/key widths and a width helper for the
// SWAN256 engine arbiter.
package swan256_engine_arbiter_pkg;

    localparam int SWAN_BLOCK_SIZE = 256;
    localparam int SWAN_KEY_SIZE   = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        RESP      = 3'd4
    } state_t;

    // Never returns less than 1 so a 2-entry index still gets a real bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/swan256_engine_arbiter_rr.sv
// Combinational round-robin picker: first asserted request after the pointer,
// wrapping around, so the last winner gets the lowest priority.
module swan_rr_arbiter
    import swan256_engine_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [clog2(NUM_REQ)-1:0] o_idx,
    output logic                      o_any
);

    localparam int IW = clog2(NUM_REQ);

    logic [IW-1:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = IW'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end

endmodule

// File: rtl/swan256_engine_arbiter.sv
// Shares one serial SWAN256 ENC/DEC engine among NUM_REQ requesters: round-robin
// grant, start sequencing around the stale-ready flag, result buffering, watchdog.
module swan256_engine_arbiter
    import swan256_engine_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int BLOCK_SIZE = SWAN_BLOCK_SIZE,
    parameter int KEY_SIZE   = SWAN_KEY_SIZE,
    parameter int TIMEOUT    = 200,
    parameter int CW         = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_mode,
    input  logic [NUM_REQ*BLOCK_SIZE-1:0] req_data,
    input  logic [NUM_REQ*KEY_SIZE-1:0]   req_key,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [clog2(NUM_REQ)-1:0]     resp_id,
    output logic                          resp_err,
    output logic [BLOCK_SIZE-1:0]         resp_data,
    output logic                          eng_start,
    output logic                          eng_mode,
    output logic [BLOCK_SIZE-1:0]         eng_inp,
    output logic [KEY_SIZE-1:0]           eng_key,
    output logic                          eng_rst_n,
    input  logic                          eng_ready,
    input  logic [BLOCK_SIZE-1:0]         eng_out
);

    localparam int IW = clog2(NUM_REQ);

    state_t                r_state;
    state_t                w_next;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_id;
    logic [BLOCK_SIZE-1:0] r_inp;
    logic [KEY_SIZE-1:0]   r_key;
    logic                  r_mode;
    logic [BLOCK_SIZE-1:0] r_resp_data;
    logic                  r_resp_err;
    logic [CW-1:0]         r_cnt;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [IW-1:0]         w_gidx;
    logic                  w_any;
    logic [BLOCK_SIZE-1:0] w_sel_data;
    logic [KEY_SIZE-1:0]   w_sel_key;
    logic                  w_sel_mode;
    logic                  w_timeout;
    logic                  w_done;
    logic                  w_wd_pulse;

    swan_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    always_comb begin
        w_sel_data = '0;
        w_sel_key  = '0;
        w_sel_mode = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = req_data[i*BLOCK_SIZE +: BLOCK_SIZE];
                w_sel_key  = req_key[i*KEY_SIZE +: KEY_SIZE];
                w_sel_mode = req_mode[i];
            end
        end
    end

    // A completion seen on the same cycle as the timeout takes precedence.
    always_comb begin
        w_next     = r_state;
        w_timeout  = (r_cnt == CW'(TIMEOUT));
        w_done     = 1'b0;
        w_wd_pulse = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) w_next = ISSUE;
            end
            ISSUE: begin
                w_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (w_timeout) begin
                    w_wd_pulse = 1'b1;
                    w_next     = RESP;
                end else if (!eng_ready) begin
                    w_next = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (eng_ready) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end else if (w_timeout) begin
                    w_wd_pulse = 1'b1;
                    w_next     = RESP;
                end
            end
            RESP: begin
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= IW'(NUM_REQ - 1);
            r_id        <= '0;
            r_inp       <= '0;
            r_key       <= '0;
            r_mode      <= 1'b0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ptr  <= w_gidx;
                        r_id   <= w_gidx;
                        r_inp  <= w_sel_data;
                        r_key  <= w_sel_key;
                        r_mode <= w_sel_mode;
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                end
                WAIT_LOW, WAIT_HIGH: begin
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                    if (w_done) begin
                        r_resp_data <= eng_out;
                        r_resp_err  <= 1'b0;
                    end else if (w_wd_pulse) begin
                        r_resp_data <= '0;
                        r_resp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE && !rst) ? w_gnt : '0;
    assign eng_start  = (r_state == ISSUE);
    assign eng_mode   = r_mode;
    assign eng_inp    = r_inp;
    assign eng_key    = r_key;
    assign eng_rst_n  = !(rst || w_wd_pulse);
    assign resp_valid = (r_state == RESP);
    assign resp_id    = r_id;
    assign resp_err   = r_resp_err;
    assign resp_data  = r_resp_data;

endmodule

// File: doc/swan256_engine_arbiter.md
Name: swan256_engine_arbiter

Overview:
Shares one serial SWAN256 engine pair (encrypt core and decrypt core behind a common start/ready/out interface) between NUM_REQ requesters.
- Round-robin arbitration of request-channel handshakes.
- Sequences the engine start pulse and handles the engine's stale-ready quirk.
- Buffers each result until the requester takes it.
- A watchdog recovers a hung engine by pulsing its active-low reset.
- Sits between crypto clients and the serial ENC/DEC cores.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
BLOCK_SIZE, 256, data block width
KEY_SIZE, 256, key width
TIMEOUT, 200, max cycles from start to engine ready (DEC needs 1 precompute + 128 half-rounds)
CW, 8, timeout counter width, must be at least clog2(TIMEOUT+1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept pulse
req_mode  in  NUM_REQ  per-requester: 0 = encrypt, 1 = decrypt
req_data  in  NUM_REQ*BLOCK_SIZE  flattened plaintext/ciphertext; requester i uses slice i
req_key  in  NUM_REQ*KEY_SIZE  flattened keys
resp_valid  out  1  result held valid
resp_ready  in  1  result consumed
resp_id  out  clog2(NUM_REQ)  index of the requester that owns the result
resp_err  out  1  1 = watchdog timeout, data is zero
resp_data  out  BLOCK_SIZE  result block
eng_start  out  1  engine start pulse
eng_mode  out  1  selects the ENC or DEC core
eng_inp  out  BLOCK_SIZE  engine input block
eng_key  out  KEY_SIZE  engine key
eng_rst_n  out  1  engine active-low reset
eng_ready  in  1  engine done flag
eng_out  in  BLOCK_SIZE  engine result

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE; all outputs 0 except eng_rst_n = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Counter = 0.
- eng_rst_n = !(rst | wd_pulse).
- IDLE:
  - If any req_valid, grant the first set bit searching from pointer+1 with wrap-around.
  - Same cycle: req_ready[g] = 1.
  - Latch data, key, mode and id; pointer = g; go to ISSUE.
  - If no req_valid, stay in IDLE.
  - req_ready is combinational from state and req_valid; it is never high outside IDLE.
- ISSUE (exactly 1 cycle):
  - eng_start = 1; eng_inp, eng_key, eng_mode driven from the latches.
  - eng_inp/eng_key/eng_mode stay stable from ISSUE through the end of WAIT_HIGH.
  - Go to WAIT_LOW; counter = 0.
- WAIT_LOW:
  - eng_ready is stale here: it reads 1 from the previous job until the engine consumes start.
  - Stay until eng_ready = 0, then go to WAIT_HIGH.
  - Counter increments each cycle.
- WAIT_HIGH:
  - On eng_ready = 1: resp_data = eng_out, resp_err = 0, go to RESP.
  - Counter increments each cycle.
- Watchdog (WAIT_LOW or WAIT_HIGH): when counter reaches TIMEOUT:
  - wd_pulse = 1 for one cycle, so eng_rst_n = 0.
  - resp_data = 0, resp_err = 1, go to RESP.
- RESP:
  - resp_valid = 1; resp_id, resp_err and resp_data held stable.
  - On resp_ready = 1, go to IDLE; resp_valid = 0 next cycle.
  - No new grant in the same cycle; the earliest next req_ready is the cycle after returning to IDLE.
- Throughput limits:
  - One job in flight.
  - A requester whose req_valid drops before grant is simply skipped.
  - req_valid from other requesters during a job is ignored until IDLE.
- Round-robin fairness: with all requesters valid, grants go 0, 1, …, NUM_REQ-1, 0, …
- Reset mid-job: rst takes priority over all state.
  - Any in-flight result is discarded and resp_valid = 0.
  - eng_rst_n = 0 during rst.
- Boundary conditions:
  - eng_ready = 1 on the very first WAIT_HIGH cycle is accepted.
  - Counter saturates and does not wrap.
  - Timeout and eng_ready in the same cycle: eng_ready wins, resp_err = 0.

Decomposition:
- Shared package:
  - state encoding IDLE=0, ISSUE=1, WAIT_LOW=2, WAIT_HIGH=3, RESP=4
  - BLOCK_SIZE and KEY_SIZE constants
  - clog2 function
- One sub-module: swan_rr_arbiter, a combinational round-robin priority picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any.
- The FSM, latches and watchdog stay in the top module.

Test Plan:
- Single request: req 0, mode 0, data 256'h1, key 256'h2. Engine stub behaviour:
  - eng_ready low 1 cycle after start, high 130 cycles later, eng_out = data^key.
  - Required: req_ready 1 cycle; eng_start 1 cycle, exactly 1 cycle after grant.
  - Required: resp_valid with resp_data 256'h3, resp_id 0, resp_err 0.
- Stale ready: stub holds eng_ready = 1 until the first edge after start.
  - Required: no premature completion; result is captured only on the second rise.
- Round-robin fairness: NUM_REQ=2, both requesters valid continuously for 4 jobs.
  - Required: resp_id sequence 0, 1, 0, 1.
  - Required: the modes passed on eng_mode match each grantee's req_mode.
- Backpressure: resp_ready held 0 for 20 cycles.
  - Required: resp_data stable, no req_ready asserted.
  - Required: after release, the next grant is in the cycle following return to IDLE.
- Watchdog: stub never raises eng_ready.
  - Required: exactly TIMEOUT counted cycles, then one cycle of eng_rst_n = 0.
  - Required: resp_err 1, resp_data 0; a following job then completes normally.
- Reset mid-job: rst = 1 during WAIT_HIGH.
  - Required next cycle: all outputs 0, eng_rst_n = 0.
  - Required: the first grant after reset goes to requester 0.
